rename_map_table: RTL and testbench
===================================

Name: rename_map_table

Overview:
- Rename-stage register map table sitting directly upstream of the physical-register free list.
- Each cycle it renames up to N instructions:
  - looks up source pregs and their ready bits;
  - requests N-or-fewer new pregs from the free list;
  - records the new destination mappings;
  - returns Told (the previous mapping) for the ROB.
- Tracks per-preg ready bits from CDB broadcasts.
- On branch mispredict, restores the whole table from the architectural map.

Parameters:
N, 3, rename width (slots per cycle)
ARCH_REG_SZ, 32, architectural register count; areg 0 is the hardwired zero register
PHYS_REG_SZ, 64, physical register count
PHYS_REG_BITS, 6, preg index width = clog2(PHYS_REG_SZ)
AREG_BITS, 5, areg index width = clog2(ARCH_REG_SZ)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rename_valid  in  N  slot k holds a valid instruction that writes a destination
dest_areg  in  N x AREG_BITS  destination areg per slot
src1_areg  in  N x AREG_BITS  source 1 areg per slot
src2_areg  in  N x AREG_BITS  source 2 areg per slot
num_tags  out  2  number of pregs requested from free list this cycle (0..N)
new_preg  in  N x PHYS_REG_BITS  allocated pregs from free list, packed from index 0
new_preg_valid  in  N  new_preg[i] is valid
cdb_valid  in  N  CDB broadcast valid per lane
cdb_preg  in  N x PHYS_REG_BITS  completed preg per lane
branch_mispredict  in  1  flush and restore
arch_map_in  in  ARCH_REG_SZ x PHYS_REG_BITS  committed map, used on mispredict
rename_ack  out  N  slot k was renamed this cycle
src1_preg, src2_preg  out  N x PHYS_REG_BITS  renamed sources
src1_ready, src2_ready  out  N  source value available
told_preg  out  N x PHYS_REG_BITS  previous mapping of dest_areg (to ROB)
dest_preg  out  N x PHYS_REG_BITS  new mapping assigned to slot

Behaviour:
- **State:**
  - map[ARCH_REG_SZ] of PHYS_REG_BITS;
  - ready[PHYS_REG_SZ] bits.
- **Reset (reset_n low, asynchronous):**
  - map[i]=i;
  - ready all 1.
  - This matches the free list's reset state (pregs 0..31 in use).
  - All outputs are combinational from state and inputs; with all inputs 0, every output is 0 except src*_preg=0 and src*_ready=1.
- **Lookups:** combinational, same cycle, 0 latency. Table and ready updates commit at posedge clock.
- **Allocating slot:** rename_valid[k]=1 and dest_areg[k]!=0.
  - num_tags = count of allocating slots, saturating at N.
  - The free list's j-th valid preg goes to the j-th allocating slot in slot order.
- **In-order stall:**
  - Slot k is acked iff all slots < k are acked and slot k either does not allocate or has its preg available (new_preg_valid[j]=1).
  - The first unacked slot blocks all later slots: rename_ack is a prefix mask.
  - Unacked slots cause no state change.
  - Upstream holds and re-presents unacked instructions.
- **Intra-group dependences:**
  - Source of slot k matching dest of an acked allocating slot j<k: preg = dest_preg[j] of the highest such j, ready=0.
  - told_preg[k] uses the same rule; otherwise it is map[dest_areg[k]].
- **Zero register:**
  - src areg 0 gives preg 0, ready=1.
  - dest 0 does not allocate: dest_preg=0, told_preg=0.
  - ready[0] is always 1.
- **Commit at posedge:**
  - For each acked allocating slot: map[dest]=new preg, with the latest slot winning for the same dest; ready[new preg]=0.
  - For each cdb_valid lane: ready[cdb_preg]=1.
  - Rename clear beats CDB set on the same preg in the same cycle.
- **branch_mispredict=1:**
  - rename_ack=0 and num_tags=0.
  - Next state: map=arch_map_in, ready all 1.
  - CDB inputs are ignored that cycle.
  - Mispredict has priority over everything except reset.
- **Reset mid-operation:** immediately forces the reset state; in-flight renames are lost.

Optional Feature:
- Macro: RENAME_MAP_TABLE_CDB_BYPASS_EN.
- **Defined:**
  - src*_ready is also 1 when the looked-up preg matches a cdb_valid lane this cycle.
  - This applies only to map-sourced lookups, not intra-group forwarded sources.
- **Undefined:**
  - src*_ready reflects only the registered ready bits.
  - The consumer sees readiness one cycle later.

Test Plan:
- **Reset:** assert reset_n=0 mid-cycle → outputs show map[i]=i immediately. Then src1_areg=7 → src1_preg=7, src1_ready=1.
- **Basic rename:** slots 0-2 with dest 3,4,5 and new_preg 40,41,42 → num_tags=3, ack=111, told=3,4,5. Next cycle src1_areg=4 → preg 41, ready 0.
- **Intra-group:** slot0 dest 5, slot1 src1 5 and dest 5, slot2 src2 5 → slot1 src1=40 (ready 0), told[1]=40; slot2 src2=41; map[5]=41 afterwards.
- **Stall:** slots 0-2 allocate, new_preg_valid=001 → ack=001, map changes only for slot0. Re-presenting with valid=111 → ack=111.
- **CDB:** cdb_preg=41 → next cycle areg 4 ready=1. Same-cycle rename of 41 plus CDB 41 → ready stays 0. With the bypass macro defined, a same-cycle lookup of a CDB-matching preg sees ready=1.
- **Mispredict:** after renames, branch_mispredict with arch_map_in[i]=i+32 → ack=0 that cycle. Next cycle src areg 3 → preg 35, ready=1.

Source files
------------

// File: rtl/rename_map_table.sv
// -----------------------------------------------------------------------------
// rename_map_table
//
// Rename-stage register map table. It sits directly upstream of the physical
// register free list and renames up to N instructions per cycle, strictly in
// slot order.
//
// For each slot it:
//   - looks up the source pregs and their ready bits;
//   - hands out free-list pregs to the slots that write a destination;
//   - returns Told, the previous mapping of the destination, for the ROB.
//
// Per-preg ready bits are set by CDB broadcasts. A branch mispredict reloads
// the whole table from the committed architectural map.
//
// Lookups are combinational (0 latency). Table and ready updates commit on the
// rising clock edge.
//
// Optional build macro: RENAME_MAP_TABLE_CDB_BYPASS_EN
//   Defined  : a map-sourced lookup also reports ready when its preg matches a
//              valid CDB lane in the same cycle.
//   Undefined: ready reflects only the registered ready bits.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   rename_valid       slot holds a valid instruction
//   dest_areg          destination areg per slot
//   src1/src2_areg     source aregs per slot
//   num_tags           number of pregs requested from the free list (0..N)
//   new_preg           pregs offered by the free list, packed from index 0
//   new_preg_valid     validity of each offered preg
//   cdb_valid/preg     completion broadcasts, one per lane
//   branch_mispredict  flush and restore from arch_map_in
//   arch_map_in        committed areg->preg map
//   rename_ack         prefix mask of slots renamed this cycle
//   src1/src2_preg     renamed sources
//   src1/src2_ready    source value available
//   told_preg          previous mapping of dest_areg (0 unless acked and allocating)
//   dest_preg          new mapping (0 unless acked and allocating)
// -----------------------------------------------------------------------------

// Per-slot lookup.
//
// A source (or the Told of the destination) normally comes from the map table.
// It is instead forwarded from the youngest older slot in the same group that
// was granted a new preg for the same areg. Forwarded sources are never ready,
// because that producer has not even issued yet.
module rename_map_table_slot #(
   parameter int N             = 3,
   parameter int PHYS_REG_BITS = 6,
   parameter int AREG_BITS     = 5
) (
   input  logic [AREG_BITS-1:0]              src1_areg,
   input  logic [AREG_BITS-1:0]              src2_areg,
   input  logic [AREG_BITS-1:0]              dest_areg,
   input  logic [PHYS_REG_BITS-1:0]          src1_map,
   input  logic [PHYS_REG_BITS-1:0]          src2_map,
   input  logic [PHYS_REG_BITS-1:0]          dest_map,
   input  logic                              src1_map_ready,
   input  logic                              src2_map_ready,
   input  logic                              grant,       // acked and allocating
   input  logic [N-1:0]                      older_en,    // older granted slots
   input  logic [N-1:0][AREG_BITS-1:0]       older_areg,
   input  logic [N-1:0][PHYS_REG_BITS-1:0]   older_preg,
   output logic [PHYS_REG_BITS-1:0]          src1_preg,
   output logic                              src1_ready,
   output logic [PHYS_REG_BITS-1:0]          src2_preg,
   output logic                              src2_ready,
   output logic [PHYS_REG_BITS-1:0]          told_preg
);

   // Result is packed as {hit, preg}. A higher slot index is younger, so a
   // later match in the loop overrides an earlier one.
   function automatic logic [PHYS_REG_BITS:0] resolve(
      input logic [AREG_BITS-1:0]     a,
      input logic [PHYS_REG_BITS-1:0] base
   );
      logic [PHYS_REG_BITS:0] r;
      r = {1'b0, base};
      for (int j = 0; j < N; j++) begin
         if (older_en[j] && (older_areg[j] == a)) begin
            r = {1'b1, older_preg[j]};
         end
      end
      return r;
   endfunction

   logic [PHYS_REG_BITS:0] s1_res, s2_res, told_res;
   logic                   s1_zero, s2_zero;

   assign s1_res   = resolve(src1_areg, src1_map);
   assign s2_res   = resolve(src2_areg, src2_map);
   assign told_res = resolve(dest_areg, dest_map);

   assign s1_zero = (src1_areg == '0);
   assign s2_zero = (src2_areg == '0);

   // areg 0 is the hardwired zero register. No older slot can ever forward to
   // it, because a dest of 0 never allocates.
   assign src1_preg  = s1_zero ? '0 : s1_res[PHYS_REG_BITS-1:0];
   assign src2_preg  = s2_zero ? '0 : s2_res[PHYS_REG_BITS-1:0];
   assign src1_ready = s1_zero | (~s1_res[PHYS_REG_BITS] & src1_map_ready);
   assign src2_ready = s2_zero | (~s2_res[PHYS_REG_BITS] & src2_map_ready);
   assign told_preg  = grant ? told_res[PHYS_REG_BITS-1:0] : '0;

endmodule

module rename_map_table #(
   parameter int N             = 3,
   parameter int ARCH_REG_SZ   = 32,
   parameter int PHYS_REG_SZ   = 64,
   parameter int PHYS_REG_BITS = $clog2(PHYS_REG_SZ),
   parameter int AREG_BITS     = $clog2(ARCH_REG_SZ)
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  logic [N-1:0]                              rename_valid,
   input  logic [N-1:0][AREG_BITS-1:0]               dest_areg,
   input  logic [N-1:0][AREG_BITS-1:0]               src1_areg,
   input  logic [N-1:0][AREG_BITS-1:0]               src2_areg,
   output logic [1:0]                                num_tags,
   input  logic [N-1:0][PHYS_REG_BITS-1:0]           new_preg,
   input  logic [N-1:0]                              new_preg_valid,
   input  logic [N-1:0]                              cdb_valid,
   input  logic [N-1:0][PHYS_REG_BITS-1:0]           cdb_preg,
   input  logic                                      branch_mispredict,
   input  logic [ARCH_REG_SZ-1:0][PHYS_REG_BITS-1:0] arch_map_in,
   output logic [N-1:0]                              rename_ack,
   output logic [N-1:0][PHYS_REG_BITS-1:0]           src1_preg,
   output logic [N-1:0][PHYS_REG_BITS-1:0]           src2_preg,
   output logic [N-1:0]                              src1_ready,
   output logic [N-1:0]                              src2_ready,
   output logic [N-1:0][PHYS_REG_BITS-1:0]           told_preg,
   output logic [N-1:0][PHYS_REG_BITS-1:0]           dest_preg
);

   localparam int CW = $clog2(N + 1);

   logic [ARCH_REG_SZ-1:0][PHYS_REG_BITS-1:0] map_q, map_nxt;
   logic [PHYS_REG_SZ-1:0]                    ready_q, ready_nxt;

   logic [N-1:0]                    alloc;       // wants a new preg
   logic [N-1:0]                    ack_alloc;   // acked and allocating
   logic [N-1:0][PHYS_REG_BITS-1:0] grant_preg;  // free-list preg lined up with slot
   logic [CW-1:0]                   req_cnt;

   // Allocation and in-order acknowledge.
   //
   // The j-th allocating slot takes the j-th free-list entry. The ack chain
   // breaks at the first slot that is invalid or whose preg is missing, so
   // rename_ack is always a prefix mask. num_tags counts every allocating slot,
   // including ones stalled behind the break, so that the free list sees the
   // full demand.
   always_comb begin
      logic chain;
      chain      = ~branch_mispredict;
      req_cnt    = '0;
      alloc      = '0;
      ack_alloc  = '0;
      rename_ack = '0;
      grant_preg = '0;
      for (int k = 0; k < N; k++) begin
         alloc[k]      = rename_valid[k] && (dest_areg[k] != '0);
         chain         = chain && rename_valid[k] &&
                         (!alloc[k] || new_preg_valid[req_cnt]);
         rename_ack[k] = chain;
         ack_alloc[k]  = chain && alloc[k];
         grant_preg[k] = new_preg[req_cnt];
         if (alloc[k]) begin
            req_cnt = CW'(req_cnt + 1'b1);
         end
      end
      num_tags = branch_mispredict ? 2'd0 : 2'(req_cnt);
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      localparam logic [N-1:0] OLDER = N'((1 << k) - 1);

      logic [PHYS_REG_BITS-1:0] s1_map, s2_map;
      logic                     s1_byp, s2_byp;

      assign s1_map = map_q[src1_areg[k]];
      assign s2_map = map_q[src2_areg[k]];

`ifdef RENAME_MAP_TABLE_CDB_BYPASS_EN
      // Same-cycle wakeup for map-sourced lookups. Forwarded sources ignore
      // this path because the slot module masks their ready bit off.
      always_comb begin
         s1_byp = 1'b0;
         s2_byp = 1'b0;
         for (int l = 0; l < N; l++) begin
            if (cdb_valid[l] && (cdb_preg[l] == s1_map)) s1_byp = 1'b1;
            if (cdb_valid[l] && (cdb_preg[l] == s2_map)) s2_byp = 1'b1;
         end
      end
`else
      assign s1_byp = 1'b0;
      assign s2_byp = 1'b0;
`endif

      assign dest_preg[k] = ack_alloc[k] ? grant_preg[k] : '0;

      rename_map_table_slot #(
         .N             (N),
         .PHYS_REG_BITS (PHYS_REG_BITS),
         .AREG_BITS     (AREG_BITS)
      ) u_slot (
         .src1_areg      (src1_areg[k]),
         .src2_areg      (src2_areg[k]),
         .dest_areg      (dest_areg[k]),
         .src1_map       (s1_map),
         .src2_map       (s2_map),
         .dest_map       (map_q[dest_areg[k]]),
         .src1_map_ready (ready_q[s1_map] | s1_byp),
         .src2_map_ready (ready_q[s2_map] | s2_byp),
         .grant          (ack_alloc[k]),
         .older_en       (ack_alloc & OLDER),
         .older_areg     (dest_areg),
         .older_preg     (grant_preg),
         .src1_preg      (src1_preg[k]),
         .src1_ready     (src1_ready[k]),
         .src2_preg      (src2_preg[k]),
         .src2_ready     (src2_ready[k]),
         .told_preg      (told_preg[k])
      );
   end

   // Normal next state.
   //
   // CDB sets are applied first and rename clears second, so a preg that is
   // re-allocated in the same cycle it completes ends up not ready. Slots are
   // walked oldest first, so the youngest write to an areg wins.
   always_comb begin
      map_nxt   = map_q;
      ready_nxt = ready_q;
      for (int l = 0; l < N; l++) begin
         if (cdb_valid[l]) ready_nxt[cdb_preg[l]] = 1'b1;
      end
      for (int k = 0; k < N; k++) begin
         if (ack_alloc[k]) begin
            map_nxt[dest_areg[k]]    = grant_preg[k];
            ready_nxt[grant_preg[k]] = 1'b0;
         end
      end
      ready_nxt[0] = 1'b1;
   end

   // On reset, areg i maps to preg i, which matches the free list holding
   // pregs 0..ARCH_REG_SZ-1 as in use.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ARCH_REG_SZ; i++) begin
            map_q[i] <= PHYS_REG_BITS'(i);
         end
         ready_q <= '1;
      end else if (branch_mispredict) begin
         map_q   <= arch_map_in;
         ready_q <= '1;
      end else begin
         map_q   <= map_nxt;
         ready_q <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed steps followed by random traffic.
// Every cycle is compared against a sequential rename model. The model renames
// the slots one at a time against a working copy of the map.
module tb_rename_map_table;
   localparam int N = 3, ARCH = 32, PHYS = 64, PB = 6, AB = 5;

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic [N-1:0]              rename_valid;
   logic [N-1:0][AB-1:0]      dest_areg, src1_areg, src2_areg;
   logic [1:0]                num_tags;
   logic [N-1:0][PB-1:0]      new_preg;
   logic [N-1:0]              new_preg_valid;
   logic [N-1:0]              cdb_valid;
   logic [N-1:0][PB-1:0]      cdb_preg;
   logic                      branch_mispredict;
   logic [ARCH-1:0][PB-1:0]   arch_map_in;
   logic [N-1:0]              rename_ack;
   logic [N-1:0][PB-1:0]      src1_preg, src2_preg, told_preg, dest_preg;
   logic [N-1:0]              src1_ready, src2_ready;

   rename_map_table dut (
      .clock(clock), .reset_n(reset_n), .rename_valid(rename_valid),
      .dest_areg(dest_areg), .src1_areg(src1_areg), .src2_areg(src2_areg),
      .num_tags(num_tags), .new_preg(new_preg), .new_preg_valid(new_preg_valid),
      .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
      .branch_mispredict(branch_mispredict), .arch_map_in(arch_map_in),
      .rename_ack(rename_ack), .src1_preg(src1_preg), .src2_preg(src2_preg),
      .src1_ready(src1_ready), .src2_ready(src2_ready),
      .told_preg(told_preg), .dest_preg(dest_preg)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference state.
   int m_map[ARCH];
   bit m_ready[PHYS];
   int m_view[ARCH];
   bit m_fresh[ARCH];
   int m_clr[$];

   // Expected outputs for the current cycle.
   logic [N-1:0]         e_ack, e_s1r, e_s2r;
   logic [1:0]           e_num;
   logic [N-1:0][PB-1:0] e_s1p, e_s2p, e_told, e_dest;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ARCH; i++) m_map[i] = i;
      for (int p = 0; p < PHYS; p++) m_ready[p] = 1'b1;
      m_clr.delete();
   endtask

   function automatic bit cdb_hit(input int p);
      bit h = 1'b0;
`ifdef RENAME_MAP_TABLE_CDB_BYPASS_EN
      for (int l = 0; l < N; l++) if (cdb_valid[l] && int'(cdb_preg[l]) == p) h = 1'b1;
`endif
      return h;
   endfunction

   function automatic void look(input int a, output int p, output bit r);
      if (a == 0) begin p = 0; r = 1'b1; end
      else if (m_fresh[a]) begin p = m_view[a]; r = 1'b0; end
      else begin p = m_view[a]; r = m_ready[p] || cdb_hit(p); end
   endfunction

   // Rename the slots one by one. An acked allocating slot rewrites the
   // working map, so later slots in the group see its new preg (not ready).
   task automatic predict();
      int  j, p, d;
      bit  r, al, blocked;
      for (int i = 0; i < ARCH; i++) begin m_view[i] = m_map[i]; m_fresh[i] = 1'b0; end
      m_clr.delete();
      e_ack = '0; e_told = '0; e_dest = '0;
      j = 0;
      blocked = branch_mispredict;
      for (int k = 0; k < N; k++) begin
         d  = int'(dest_areg[k]);
         al = rename_valid[k] && d != 0;
         look(int'(src1_areg[k]), p, r); e_s1p[k] = PB'(p); e_s1r[k] = r;
         look(int'(src2_areg[k]), p, r); e_s2p[k] = PB'(p); e_s2r[k] = r;
         if (!blocked && rename_valid[k] && (!al || new_preg_valid[j])) begin
            e_ack[k] = 1'b1;
            if (al) begin
               e_told[k] = PB'(m_view[d]);
               e_dest[k] = new_preg[j];
               m_view[d] = int'(new_preg[j]);
               m_fresh[d] = 1'b1;
               m_clr.push_back(int'(new_preg[j]));
            end
         end else blocked = 1'b1;
         if (al) j++;
      end
      e_num = branch_mispredict ? 2'd0 : 2'(j);
   endtask

   task automatic commit_model();
      if (!reset_n) model_reset();
      else if (branch_mispredict) begin
         for (int i = 0; i < ARCH; i++) m_map[i] = int'(arch_map_in[i]);
         for (int p = 0; p < PHYS; p++) m_ready[p] = 1'b1;
      end else begin
         for (int l = 0; l < N; l++) if (cdb_valid[l]) m_ready[cdb_preg[l]] = 1'b1;
         foreach (m_clr[i]) m_ready[m_clr[i]] = 1'b0;
         for (int i = 0; i < ARCH; i++) m_map[i] = m_view[i];
         m_ready[0] = 1'b1;
      end
      m_clr.delete();
   endtask

   task automatic compare_all(input string t);
      check({t, ".ack"},   64'(rename_ack), 64'(e_ack));
      check({t, ".num"},   64'(num_tags),   64'(e_num));
      check({t, ".s1p"},   64'(src1_preg),  64'(e_s1p));
      check({t, ".s1r"},   64'(src1_ready), 64'(e_s1r));
      check({t, ".s2p"},   64'(src2_preg),  64'(e_s2p));
      check({t, ".s2r"},   64'(src2_ready), 64'(e_s2r));
      check({t, ".told"},  64'(told_preg),  64'(e_told));
      check({t, ".dest"},  64'(dest_preg),  64'(e_dest));
   endtask

   task automatic eval(input string t);
      @(negedge clock);
      predict();
      compare_all(t);
   endtask

   task automatic commit();
      @(posedge clock);
      commit_model();
      #1;
   endtask

   task automatic clr();
      rename_valid = '0; dest_areg = '0; src1_areg = '0; src2_areg = '0;
      new_preg = '0; new_preg_valid = '0; cdb_valid = '0; cdb_preg = '0;
      branch_mispredict = 1'b0;
   endtask

   task automatic slot(input int k, input int d, input int s1, input int s2);
      rename_valid[k] = 1'b1;
      dest_areg[k] = AB'(d); src1_areg[k] = AB'(s1); src2_areg[k] = AB'(s2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      clr();
      for (int i = 0; i < ARCH; i++) arch_map_in[i] = PB'(i);
      model_reset();

      // Reset state, all inputs zero.
      eval("reset");
      check("reset.ack", 64'(rename_ack), 64'd0);
      check("reset.s1r", 64'(src1_ready), 64'h7);
      reset_n = 1'b1;
      commit();

      // Identity lookup.
      src1_areg[0] = 5'd7;
      eval("ident");
      check("ident.s1p0", 64'(src1_preg[0]), 64'd7);
      check("ident.s1r0", 64'(src1_ready[0]), 64'd1);
      commit();

      // Basic rename: dest 3,4,5 get pregs 40,41,42.
      clr();
      slot(0, 3, 1, 2); slot(1, 4, 1, 2); slot(2, 5, 1, 2);
      new_preg = {6'd42, 6'd41, 6'd40}; new_preg_valid = 3'b111;
      eval("basic");
      check("basic.num", 64'(num_tags), 64'd3);
      check("basic.ack", 64'(rename_ack), 64'h7);
      check("basic.told0", 64'(told_preg[0]), 64'd3);
      check("basic.told1", 64'(told_preg[1]), 64'd4);
      check("basic.told2", 64'(told_preg[2]), 64'd5);
      commit();

      // Lookup of the fresh mapping, with a CDB for preg 41 in the same cycle.
      clr();
      src1_areg[0] = 5'd4; cdb_valid = 3'b001; cdb_preg[0] = 6'd41;
      eval("after_basic");
      check("after_basic.s1p0", 64'(src1_preg[0]), 64'd41);
      commit();
      clr();
      src1_areg[0] = 5'd4;
      eval("cdb_next");
      check("cdb_next.s1r0", 64'(src1_ready[0]), 64'd1);
      commit();

      // Re-allocate preg 41 while the CDB also broadcasts 41: the clear wins.
      clr();
      slot(0, 6, 0, 0); new_preg[0] = 6'd41; new_preg_valid = 3'b001;
      cdb_valid = 3'b010; cdb_preg[1] = 6'd41;
      eval("clr_vs_cdb");
      commit();
      clr();
      src1_areg[0] = 5'd6;
      eval("clr_vs_cdb_next");
      check("clr_vs_cdb.s1r0", 64'(src1_ready[0]), 64'd0);
      commit();

      // Intra-group dependences.
      clr();
      slot(0, 5, 1, 2); slot(1, 5, 5, 0); slot(2, 0, 0, 5);
      new_preg = {6'd0, 6'd41, 6'd40}; new_preg_valid = 3'b011;
      eval("intra");
      check("intra.s1p1", 64'(src1_preg[1]), 64'd40);
      check("intra.s1r1", 64'(src1_ready[1]), 64'd0);
      check("intra.told1", 64'(told_preg[1]), 64'd40);
      check("intra.told0", 64'(told_preg[0]), 64'd42);
      check("intra.s2p2", 64'(src2_preg[2]), 64'd41);
      check("intra.num", 64'(num_tags), 64'd2);
      commit();
      clr();
      src1_areg[0] = 5'd5;
      eval("intra_next");
      check("intra_next.s1p0", 64'(src1_preg[0]), 64'd41);
      commit();

      // Stall: only the first preg is available.
      clr();
      slot(0, 7, 0, 0); slot(1, 8, 0, 0); slot(2, 9, 0, 0);
      new_preg = {6'd52, 6'd51, 6'd50}; new_preg_valid = 3'b001;
      eval("stall");
      check("stall.ack", 64'(rename_ack), 64'h1);
      check("stall.num", 64'(num_tags), 64'd3);
      commit();
      clr();
      slot(0, 8, 7, 8); slot(1, 9, 0, 0); slot(2, 10, 0, 0);
      new_preg = {6'd53, 6'd52, 6'd51}; new_preg_valid = 3'b111;
      eval("represent");
      check("represent.ack", 64'(rename_ack), 64'h7);
      check("represent.s1p0", 64'(src1_preg[0]), 64'd50);
      check("represent.s2p0", 64'(src2_preg[0]), 64'd8);
      commit();

      // Mispredict: restore to i+32.
      clr();
      for (int i = 0; i < ARCH; i++) arch_map_in[i] = PB'(i + 32);
      slot(0, 3, 1, 1); slot(1, 4, 2, 2);
      new_preg = {6'd0, 6'd61, 6'd60}; new_preg_valid = 3'b011;
      cdb_valid = 3'b001; cdb_preg[0] = 6'd50;
      branch_mispredict = 1'b1;
      eval("mispred");
      check("mispred.ack", 64'(rename_ack), 64'd0);
      check("mispred.num", 64'(num_tags), 64'd0);
      commit();
      clr();
      src1_areg[0] = 5'd3;
      eval("mispred_next");
      check("mispred_next.s1p0", 64'(src1_preg[0]), 64'd35);
      check("mispred_next.s1r0", 64'(src1_ready[0]), 64'd1);
      commit();

      // Asynchronous reset in the middle of a cycle.
      clr();
      src1_areg[0] = 5'd3;
      #2 reset_n = 1'b0;
      #1;
      check("async_rst.s1p0", 64'(src1_preg[0]), 64'd3);
      check("async_rst.s1r0", 64'(src1_ready[0]), 64'd1);
      model_reset();
      eval("in_reset");
      #1 reset_n = 1'b1;
      commit();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         clr();
         for (int k = 0; k < N; k++) begin
            rename_valid[k] = ($urandom_range(0, 4) != 0);
            dest_areg[k] = ($urandom_range(0, 5) == 0) ? 5'd0 : AB'($urandom_range(1, 31));
            src1_areg[k] = AB'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            src2_areg[k] = AB'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            new_preg[k] = PB'($urandom_range(1, 63));
            cdb_valid[k] = $urandom_range(0, 1);
            cdb_preg[k] = PB'($urandom_range(0, 63));
         end
         if ($urandom_range(0, 2) == 0) new_preg_valid = N'($urandom);
         else new_preg_valid = N'((1 << $urandom_range(0, N)) - 1);
         branch_mispredict = ($urandom_range(0, 19) == 0);
         if (branch_mispredict)
            for (int i = 0; i < ARCH; i++) arch_map_in[i] = PB'($urandom_range(0, 63));
         eval($sformatf("rnd%0d", c));
         commit();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
